// File: rtl/linebuf_pkg.sv
// linebuf_pkg: shared sizes and address helper for the line buffer counters
package linebuf_pkg;
    localparam int DEF_LINE_W = 2;
    localparam int DEF_CHAR_W = 9;
    localparam int NUM_LINES  = 1 << DEF_LINE_W;
    localparam int ADDR_W     = DEF_LINE_W + DEF_CHAR_W;

    typedef logic [ADDR_W-1:0] addr_t;

    function automatic addr_t mk_addr(input logic [DEF_LINE_W-1:0] line, input logic [DEF_CHAR_W-1:0] ch);
        return {line, ch};
    endfunction
endpackage

// File: rtl/linebuf_len_table.sv
// linebuf_len_table: per-line last-char index, sync write, async read
module linebuf_len_table
    import linebuf_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int CHAR_W = DEF_CHAR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [CHAR_W-1:0] wr_len,
    input  logic [LINE_W-1:0] rd_line,
    output logic [CHAR_W-1:0] rd_len
);
    logic [CHAR_W-1:0] len [1 << LINE_W];

    // record the last-char index of a line as it is committed
    always_ff @(posedge clk) begin
        if (we) len[wr_line] <= wr_len;
    end

    assign rd_len = len[rd_line];
endmodule

// File: rtl/linebuf_counters.sv
// linebuf_counters: write/read line and char pointers, line count and flags
module linebuf_counters
    import linebuf_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int CHAR_W = DEF_CHAR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_char_incr,
    input  logic                     wr_newline,
    input  logic                     rd_char_incr,
    input  logic                     rd_newline,
    output logic [LINE_W+CHAR_W-1:0] wr_addr,
    output logic [LINE_W+CHAR_W-1:0] rd_addr,
    output logic                     greenflag,
    output logic                     lastflag,
    output logic                     fullflag,
    output logic                     wr_err
);
    logic [LINE_W-1:0] wr_line, rd_line;
    logic [CHAR_W-1:0] wr_char, rd_char, rd_len;
    logic [LINE_W:0]   count;
    logic              commit, rel, wr_sat;

    assign commit    = wr_newline & ~fullflag;
    assign rel       = rd_newline & greenflag;
    assign wr_sat    = wr_char_incr & ~wr_newline & (&wr_char);
    assign greenflag = count != '0;
    assign fullflag  = count[LINE_W];
    assign lastflag  = greenflag & (rd_char == rd_len);
    assign wr_addr   = mk_addr(wr_line, wr_char);
    assign rd_addr   = mk_addr(rd_line, rd_char);

    linebuf_len_table #(.LINE_W(LINE_W), .CHAR_W(CHAR_W)) u_len (
        .clk(clk),
        .we(commit),
        .wr_line(wr_line),
        .wr_len(wr_char),
        .rd_line(rd_line),
        .rd_len(rd_len)
    );

    // write pointer: commit wins over increment, char saturates, illegal beats flag wr_err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_line <= '0;
            wr_char <= '0;
            wr_err  <= 1'b0;
        end else begin
            wr_err <= fullflag ? (wr_char_incr | wr_newline) : wr_sat;
            if (commit) begin
                wr_line <= wr_line + 1'b1;
                wr_char <= '0;
            end else if (wr_char_incr & ~fullflag & ~(&wr_char)) begin
                wr_char <= wr_char + 1'b1;
            end
        end
    end

    // read pointer: release wins over increment, char holds at line end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_line <= '0;
            rd_char <= '0;
        end else if (rel) begin
            rd_line <= rd_line + 1'b1;
            rd_char <= '0;
        end else if (rd_char_incr & greenflag & ~lastflag) begin
            rd_char <= rd_char + 1'b1;
        end
    end

    // committed-line count; commit and release in one cycle cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count + (LINE_W+1)'(commit) - (LINE_W+1)'(rel);
    end
endmodule
